// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV64 funct3 codes, FSM state
// encoding and the access-size helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_ISSUE,
    S_LD_CAPTURE,
    S_RMW_ISSUE,
    S_RMW_CAPTURE,
    S_ST_WRITE,
    S_RESP
  } lsu_state_t;

  // Access size in bytes; the unsigned variants share the low two bits with the signed ones.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    logic [3:0] size;
    case (funct3[1:0])
      2'b00:   size = 4'd1;
      2'b01:   size = 4'd2;
      2'b10:   size = 4'd4;
      default: size = 4'd8;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory signals of the load/store unit,
// with views for the pipeline (master), the unit (slave) and the memory.
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_read, mem_write, mem_address, mem_write_data
  );

  modport mem (
    input  mem_read, mem_write, mem_address, mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational data path of the load/store unit: load byte extraction with
// sign/zero extension, and byte merge of store data into a memory doubleword.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [63:0] mem_rdata_i,
  input  logic [63:0] store_wdata_i,
  output logic [63:0] load_data_o,
  output logic [63:0] store_data_o
);

  logic [3:0] size;
  assign size = size_bytes(funct3_i);

  // Low `size` bytes come from the store data, the rest keep the memory contents.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_merge
      assign store_data_o[8*gi +: 8] = (4'(gi) < size) ? store_wdata_i[8*gi +: 8]
                                                       : mem_rdata_i[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    load_data_o = mem_rdata_i;
    case (funct3_i)
      F3_B:    load_data_o = {{56{mem_rdata_i[7]}},  mem_rdata_i[7:0]};
      F3_H:    load_data_o = {{48{mem_rdata_i[15]}}, mem_rdata_i[15:0]};
      F3_W:    load_data_o = {{32{mem_rdata_i[31]}}, mem_rdata_i[31:0]};
      F3_BU:   load_data_o = {56'd0, mem_rdata_i[7:0]};
      F3_HU:   load_data_o = {48'd0, mem_rdata_i[15:0]};
      F3_WU:   load_data_o = {32'd0, mem_rdata_i[31:0]};
      default: load_data_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit over a doubleword-only data memory port; sub-word stores
// are read-modify-write. Define MISALIGN_TRAP_EN to reject misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  lsu_state_t  state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [63:0] mem_address_q, mem_address_d;
  logic [63:0] mem_write_data_q, mem_write_data_d;

  logic        accept;
  logic        range_err;
  logic        funct3_err;
  logic        align_err;
  logic        req_err;
  logic [63:0] load_data;
  logic [63:0] store_data;

  assign accept    = bus.req_valid & req_ready_q;
  // A plain compare also catches addresses whose +7 would wrap past 2^64.
  assign range_err = bus.req_addr > ADDR_MAX;
  assign funct3_err = bus.req_write ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);

`ifdef MISALIGN_TRAP_EN
  logic [3:0] acc_size;
  logic [2:0] align_mask;
  assign acc_size   = size_bytes(bus.req_funct3);
  assign align_mask = 3'(acc_size - 4'd1);
  assign align_err  = |(bus.req_addr[2:0] & align_mask);
`else
  assign align_err  = 1'b0;
`endif

  assign req_err = range_err | funct3_err | align_err;

  lsu_align u_align (
    .funct3_i      (funct3_q),
    .mem_rdata_i   (bus.mem_read_data),
    .store_wdata_i (wdata_q),
    .load_data_o   (load_data),
    .store_data_o  (store_data)
  );

  always_comb begin
    state_d          = state_q;
    funct3_d         = funct3_q;
    wdata_d          = wdata_q;
    resp_error_d     = 1'b0;
    resp_rdata_d     = 64'd0;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          funct3_d = bus.req_funct3;
          wdata_d  = bus.req_wdata;
          if (req_err) begin
            state_d      = S_RESP;
            resp_error_d = 1'b1;
          end else if (!bus.req_write) begin
            state_d       = S_LD_ISSUE;
            mem_address_d = bus.req_addr;
          end else if (bus.req_funct3 == F3_D) begin
            state_d          = S_ST_WRITE;
            mem_address_d    = bus.req_addr;
            mem_write_data_d = bus.req_wdata;
          end else begin
            state_d       = S_RMW_ISSUE;
            mem_address_d = bus.req_addr;
          end
        end
      end
      S_LD_ISSUE:    state_d = S_LD_CAPTURE;
      S_LD_CAPTURE: begin
        state_d      = S_RESP;
        resp_rdata_d = load_data;
      end
      S_RMW_ISSUE:   state_d = S_RMW_CAPTURE;
      S_RMW_CAPTURE: begin
        state_d          = S_ST_WRITE;
        mem_write_data_d = store_data;
      end
      S_ST_WRITE:    state_d = S_RESP;
      S_RESP:        state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state drives.
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    mem_read_d   = (state_d == S_LD_ISSUE) || (state_d == S_RMW_ISSUE);
    mem_write_d  = (state_d == S_ST_WRITE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      funct3_q         <= 3'd0;
      wdata_q          <= 64'd0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_error_q     <= 1'b0;
      resp_rdata_q     <= 64'd0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= 64'd0;
      mem_write_data_q <= 64'd0;
    end else begin
      state_q          <= state_d;
      funct3_q         <= funct3_d;
      wdata_q          <= wdata_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_error_q     <= resp_error_d;
      resp_rdata_q     <= resp_rdata_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_error     = resp_error_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;

endmodule
